// File: rtl/riscv_lsu.sv
// Load/store unit: turns core load/store requests into a valid/ready bus access with byte
// enables, returns extended load data, and stalls the core while the access is in flight.
// Optional build macro: LSU_MISALIGN_TRAP_EN (misaligned half/word accesses fault without a bus access).
module riscv_lsu #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        err_o,
    output logic        stall_o,
    output logic        bus_valid_o,
    input  logic        bus_ready_i,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        DONE
    } state_t;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t          state, state_next;
    logic [CW-1:0]   timeout_cnt;
    logic [2:0]      funct3_q;
    logic [1:0]      addr_lo_q;

    logic            bad_funct3;
    logic            misaligned;
    logic            reject;
    logic            timeout_hit;
    logic [3:0]      be_next;
    logic [31:0]     wdata_next;
    logic [4:0]      rd_shift;
    logic [31:0]     rd_lane;
    logic [31:0]     load_data;

    // Request decode, evaluated on the raw core inputs while IDLE.
    // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        bad_funct3 = 1'b1;
        case (funct3_i)
            3'b000, 3'b001, 3'b010: bad_funct3 = 1'b0;
            3'b100, 3'b101:         bad_funct3 = we_i;
            default:                bad_funct3 = 1'b1;
        endcase

        misaligned = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                     ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif

        be_next    = 4'b1111;
        wdata_next = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                be_next    = 4'b0001 << addr_i[1:0];
                wdata_next = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_next    = 4'b0011 << {addr_i[1], 1'b0};
                wdata_next = {2{wdata_i[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = wdata_i;
            end
        endcase
    end

    assign reject = bad_funct3 | misaligned;

    // Lane selection uses the registered low address bits; words always come from lane 0.
    always_comb begin
        rd_shift = 5'd0;
        case (funct3_q[1:0])
            2'b00:   rd_shift = {addr_lo_q, 3'b000};
            2'b01:   rd_shift = {addr_lo_q[1], 4'b0000};
            default: rd_shift = 5'd0;
        endcase
        rd_lane = bus_rdata_i >> rd_shift;

        load_data = rd_lane;
        case (funct3_q)
            3'b000:  load_data = {{24{rd_lane[7]}}, rd_lane[7:0]};
            3'b100:  load_data = {24'd0, rd_lane[7:0]};
            3'b001:  load_data = {{16{rd_lane[15]}}, rd_lane[15:0]};
            3'b101:  load_data = {16'd0, rd_lane[15:0]};
            default: load_data = rd_lane;
        endcase
        if (bus_we_o) load_data = 32'd0;
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         ((32'(timeout_cnt) + 32'd1) >= 32'(TIMEOUT_CYCLES));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_i) state_next = reject ? DONE : BUS;
            BUS:     if (bus_ready_i || timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_o     <= 32'd0;
            err_o       <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= 32'd0;
            bus_be_o    <= 4'd0;
            bus_wdata_o <= 32'd0;
            funct3_q    <= 3'd0;
            addr_lo_q   <= 2'd0;
            timeout_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i) begin
                        bus_we_o    <= we_i;
                        bus_addr_o  <= {addr_i[31:2], 2'b00};
                        bus_be_o    <= be_next;
                        bus_wdata_o <= wdata_next;
                        funct3_q    <= funct3_i;
                        addr_lo_q   <= addr_i[1:0];
                        timeout_cnt <= '0;
                        err_o       <= reject;
                        rdata_o     <= 32'd0;
                    end
                end
                BUS: begin
                    if (bus_ready_i) begin
                        rdata_o     <= load_data;
                        err_o       <= 1'b0;
                        timeout_cnt <= '0;
                    end else if (timeout_hit) begin
                        rdata_o     <= 32'd0;
                        err_o       <= 1'b1;
                        timeout_cnt <= '0;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                DONE: begin
                    rdata_o <= 32'd0;
                    err_o   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign done_o      = (state == DONE);
    assign bus_valid_o = (state == BUS);
    assign stall_o     = req_i & (state != DONE);

endmodule
